// File: rtl/sram_100_qsys_cpu_oci_dct_pkg.sv
// ----------------------------------------------------------------------------
// sram_100_qsys_cpu_oci_dct_pkg
// Shared constants and types for the OCI DCT packer.
//   CODE_W : bits per direct-compression-trace code
//   DEPTH  : codes per full frame
//   BUF_W  : frame buffer width (CODE_W*DEPTH)
//   CNT_W  : width of a code count (holds 0..DEPTH)
//   end_state_e : end-of-test sequencing states RUN -> DRAIN -> DONE
// ----------------------------------------------------------------------------
package sram_100_qsys_cpu_oci_dct_pkg;

    localparam int CODE_W = 2;
    localparam int DEPTH  = 15;
    localparam int BUF_W  = CODE_W * DEPTH;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } end_state_e;

endpackage

// File: rtl/sram_100_qsys_cpu_oci_dct_frame_reg.sv
// ----------------------------------------------------------------------------
// sram_100_qsys_cpu_oci_dct_frame_reg
// Single-slot frame register on the output side of the packer.
// Handshake: a frame is transferred on a cycle where o_valid && i_ready.
// o_valid rises on the cycle after i_load and holds until that transfer.
// The caller only asserts i_load when the slot is empty or being drained in
// the same cycle, so a load always overrides the pop (back-to-back frames).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_load            : capture i_buffer/i_count/i_ovf into the slot
//   i_buffer, i_count : frame contents
//   i_ovf             : frame follows dropped codes
//   i_ready           : downstream accepts the current frame
//   o_valid           : slot holds an unconsumed frame
//   o_buffer, o_count, o_ovf : slot contents
// ----------------------------------------------------------------------------
module sram_100_qsys_cpu_oci_dct_frame_reg
    import sram_100_qsys_cpu_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [BUF_W-1:0] i_buffer,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_ovf,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [BUF_W-1:0] o_buffer,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    logic             r_valid;
    logic [BUF_W-1:0] r_buffer;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_buffer <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_buffer <= i_buffer;
            r_count  <= i_count;
            r_ovf    <= i_ovf;
        end else if (r_valid && i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_buffer = r_buffer;
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/sram_100_qsys_cpu_oci_dct_packer.sv
// ----------------------------------------------------------------------------
// sram_100_qsys_cpu_oci_dct_packer
// Packs 2-bit DCT codes into a 30-bit live buffer (newest code in [1:0]) and
// closes frames into a single-slot valid/ready frame register. Also sequences
// the end of test: RUN -> DRAIN (end_req) -> DONE (everything drained).
// Input handshake : a code is taken on a cycle where in_valid && in_ready.
// Output handshake: a frame is taken on a cycle where out_valid && out_ready.
// Optional feature macro: DCT_OVERFLOW_MARK_EN
//   defined   : in_ready stays high in RUN; codes that arrive while stalled are
//               dropped and flagged on out_ovf of the next frame.
//   undefined : stalled codes are backpressured; out_ovf is always 0.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_code   : incoming DCT code
//   in_ready            : code accepted this cycle when in_valid
//   flush               : close a partial frame
//   end_req             : one-cycle end-of-simulation pulse
//   dct_buffer          : live accumulation buffer
//   dct_count           : live number of codes
//   out_valid/out_ready : frame handshake
//   out_buffer          : frame codes, unused MSBs zero
//   out_count           : codes in frame, 1..15
//   out_ovf             : frame follows dropped codes
//   test_ending         : high from end_req until the end
//   test_has_ended      : sticky, final frame drained
// ----------------------------------------------------------------------------
module sram_100_qsys_cpu_oci_dct_packer
    import sram_100_qsys_cpu_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    input  logic              flush,
    input  logic              end_req,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_buffer,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              test_ending,
    output logic              test_has_ended
);

    end_state_e       r_state;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_close_pend;
    logic             r_test_ending;
    logic             r_test_has_ended;

    logic             w_run;
    logic             w_stall;
    logic             w_can_load;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BUF_W-1:0] w_buf_nxt;
    logic             w_close_evt;
    logic             w_close;
    logic             w_load;
    logic             w_load_ovf;

    assign w_run      = (r_state == RUN);
    // One more code would fill the buffer, but its frame could not be loaded.
    assign w_stall    = (r_cnt == CNT_W'(DEPTH - 1)) && out_valid && !out_ready;
    assign w_can_load = !out_valid || out_ready;

`ifdef DCT_OVERFLOW_MARK_EN
    logic w_drop;
    logic r_ovf;

    assign in_ready   = w_run;
    assign w_accept   = in_valid && w_run && !w_stall;
    assign w_drop     = in_valid && w_run && w_stall;
    assign w_load_ovf = r_ovf;

    // Sticky drop flag; handed to the next loaded frame, then restarted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_ovf <= w_drop;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end
`else
    assign in_ready   = w_run && !w_stall;
    assign w_accept   = in_valid && in_ready;
    assign w_load_ovf = 1'b0;
`endif

    assign w_cnt_nxt = r_cnt + CNT_W'(w_accept);
    assign w_buf_nxt = w_accept ? {r_buf[BUF_W-CODE_W-1:0], in_code} : r_buf;

    // Outside RUN every leftover code must be flushed out, so draining acts
    // as a continuous flush. A close that could not load is remembered so a
    // partial frame still closes once the slot frees.
    assign w_close_evt = flush || (end_req && w_run) || !w_run || r_close_pend;
    assign w_close     = (w_cnt_nxt == CNT_W'(DEPTH)) ||
                         (w_close_evt && (w_cnt_nxt != '0));
    assign w_load      = w_close && w_can_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_close_pend <= 1'b0;
        end else if (w_load) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_close_pend <= 1'b0;
        end else begin
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_close_pend <= w_close;
        end
    end

    // End-of-test FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= RUN;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (end_req) begin
                        r_state       <= DRAIN;
                        r_test_ending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((r_cnt == '0) && !out_valid) begin
                        r_state          <= DONE;
                        r_test_has_ended <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    sram_100_qsys_cpu_oci_dct_frame_reg u_frame_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_buffer (w_buf_nxt),
        .i_count  (w_cnt_nxt),
        .i_ovf    (w_load_ovf),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_buffer (out_buffer),
        .o_count  (out_count),
        .o_ovf    (out_ovf)
    );

    assign dct_buffer     = r_buf;
    assign dct_count      = r_cnt;
    assign test_ending    = r_test_ending;
    assign test_has_ended = r_test_has_ended;

endmodule
